// File: rtl/smc_lite_pkg.sv
// Shared AHB-lite/APB encodings and bridge FSM states for the SMC configuration bridge.
package smc_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ENABLE = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_e;

   // Only aligned 32-bit accesses reach the register file.
   function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
      return (size == HSIZE_WORD) && (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/smc_ahb2apb_lite.sv
// AHB-lite slave to APB master bridge: one APB SETUP/ENABLE access per legal word transfer,
// two-cycle ERROR response for anything else.
module smc_ahb2apb_lite
   import smc_lite_pkg::*;
#(
   parameter int HADDR_W = 32,
   parameter int PADDR_W = 5
) (
   input  logic               pclk,
   input  logic               n_preset,
   input  logic               hsel,
   input  logic               hready_in,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [HADDR_W-1:0] haddr,
   input  logic [31:0]        hwdata,
   output logic               hreadyout,
   output logic [1:0]         hresp,
   output logic [31:0]        hrdata,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [PADDR_W-1:0] paddr,
   output logic [31:0]        pwdata,
   input  logic [31:0]        prdata
);

   bridge_state_e      state_q, state_d;
   logic [PADDR_W-1:0] paddr_q, paddr_d;
   logic               pwrite_q, pwrite_d;
   logic [31:0]        pwdata_q, pwdata_d;
   logic [31:0]        hrdata_q, hrdata_d;
   logic               xfer_valid;

   // Upper address bits are decoded by the fabric through hsel; htrans[0] only splits NONSEQ/SEQ.
   logic unused_inputs;
   assign unused_inputs = ^{haddr[HADDR_W-1:PADDR_W], htrans[0]};

   assign xfer_valid = hsel & hready_in & htrans[1];

   always_ff @(posedge pclk or negedge n_preset) begin
      if (!n_preset) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_valid) begin
               if (xfer_legal(hsize, haddr[1:0])) begin
                  paddr_d  = haddr[PADDR_W-1:0];
                  pwrite_d = hwrite;
                  state_d  = hwrite ? ST_WDATA : ST_SETUP;
               end else begin
                  state_d = ST_ERR1;
               end
            end
         end
         ST_WDATA: begin
            pwdata_d = hwdata;
            state_d  = ST_SETUP;
         end
         ST_SETUP:  state_d = ST_ENABLE;
         ST_ENABLE: begin
            if (!pwrite_q) hrdata_d = prdata;
            state_d = ST_IDLE;
         end
         ST_ERR1:   state_d = ST_ERR2;
         ST_ERR2:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // All handshake outputs decode straight from the state register so reset clears them at once.
   assign psel      = (state_q == ST_SETUP) || (state_q == ST_ENABLE);
   assign penable   = (state_q == ST_ENABLE);
   assign hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_smc_ahb2apb_lite.sv
// Directed bench for smc_ahb2apb_lite: a table of single transfers plus hand-written
// back-to-back and mid-access reset sequences.
module tb_smc_ahb2apb_lite;

   logic        pclk = 1'b0;
   logic        n_preset = 1'b0;
   logic        hsel = 1'b0;
   logic        hready_in = 1'b1;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b010;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   smc_ahb2apb_lite #(.HADDR_W(32), .PADDR_W(5)) dut (
      .pclk(pclk), .n_preset(n_preset), .hsel(hsel), .hready_in(hready_in),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
      .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .psel(psel),
      .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      string       name;
      logic        hsel;
      logic        hready_in;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic [31:0] prdata;
      int          exp_waits;
      logic        exp_err;
      logic        exp_apb;
      logic [4:0]  exp_paddr;
      logic [31:0] exp_hrdata;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive_idle();
      hsel      = 1'b0;
      hready_in = 1'b1;
      htrans    = 2'b00;
      hwrite    = 1'b0;
      hsize     = 3'b010;
      haddr     = '0;
   endtask

   task automatic drive_addr(input logic wr, input logic [31:0] addr);
      hsel      = 1'b1;
      hready_in = 1'b1;
      htrans    = 2'b10;
      hwrite    = wr;
      hsize     = 3'b010;
      haddr     = addr;
   endtask

   // Address phase in T0, data phase from T1; follows the transfer until hreadyout returns.
   task automatic run_txn(input vec_t v);
      int          waits;
      int          nsetup;
      int          nen;
      logic        psel_t1;
      logic [1:0]  first_resp;
      logic [4:0]  cap_paddr;
      logic        cap_pwrite;
      logic [31:0] cap_pwdata;
      hsel = v.hsel; hready_in = v.hready_in; htrans = v.htrans;
      hwrite = v.hwrite; hsize = v.hsize; haddr = v.haddr; prdata = v.prdata;
      step();
      drive_idle();
      hwdata = v.hwdata;
      psel_t1 = psel;
      first_resp = hresp;
      waits = 0; nsetup = 0; nen = 0;
      cap_paddr = '0; cap_pwrite = 1'b0; cap_pwdata = '0;
      while (!hreadyout && waits < 20) begin
         if (psel && !penable) nsetup++;
         if (psel && penable) begin
            nen++;
            cap_paddr  = paddr;
            cap_pwrite = pwrite;
            cap_pwdata = pwdata;
         end
         step();
         waits++;
      end
      if (waits >= 20) check({v.name, " timeout"}, 32'(waits), 32'(v.exp_waits));
      check({v.name, " waits"},   32'(waits),  32'(v.exp_waits));
      check({v.name, " psel_t1"}, 32'(psel_t1), 32'(v.exp_apb && !v.hwrite));
      check({v.name, " setups"},  32'(nsetup), 32'(v.exp_apb));
      check({v.name, " enables"}, 32'(nen),    32'(v.exp_apb));
      check({v.name, " psel_end"}, 32'(psel),  32'd0);
      check({v.name, " hresp_end"}, 32'(hresp), v.exp_err ? 32'd1 : 32'd0);
      if (v.exp_err) check({v.name, " hresp_err1"}, 32'(first_resp), 32'd1);
      check({v.name, " hrdata"}, hrdata, v.exp_hrdata);
      if (v.exp_apb) begin
         check({v.name, " paddr"},  32'(cap_paddr),  32'(v.exp_paddr));
         check({v.name, " pwrite"}, 32'(cap_pwrite), 32'(v.hwrite));
         if (v.hwrite) check({v.name, " pwdata"}, cap_pwdata, v.hwdata);
      end
      step();
      check({v.name, " settle_hresp"},  32'(hresp),     32'd0);
      check({v.name, " settle_hready"}, 32'(hreadyout), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"rd0",      1, 1, 2'b10, 0, 3'b010, 32'h0000_0000, 32'h0,          32'hA5A5_1234, 2, 0, 1, 5'h00, 32'hA5A5_1234};
      vecs[1]  = '{"wr4",      1, 1, 2'b10, 1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,          3, 0, 1, 5'h04, 32'hA5A5_1234};
      vecs[2]  = '{"wr_half",  1, 1, 2'b10, 1, 3'b001, 32'h0000_0000, 32'h1111_1111, 32'h0,          1, 1, 0, 5'h00, 32'hA5A5_1234};
      vecs[3]  = '{"idle_tr",  1, 1, 2'b00, 0, 3'b010, 32'h0000_0000, 32'h0,          32'h0,          0, 0, 0, 5'h00, 32'hA5A5_1234};
      vecs[4]  = '{"no_ready", 1, 0, 2'b10, 0, 3'b010, 32'h0000_0008, 32'h0,          32'h7777_7777, 0, 0, 0, 5'h00, 32'hA5A5_1234};
      vecs[5]  = '{"no_sel",   0, 1, 2'b10, 1, 3'b010, 32'h0000_000C, 32'h2222_2222, 32'h0,          0, 0, 0, 5'h00, 32'hA5A5_1234};
      vecs[6]  = '{"rd_hi",    1, 1, 2'b10, 0, 3'b010, 32'hFFFF_FF7C, 32'h0,          32'h1357_9BDF, 2, 0, 1, 5'h1C, 32'h1357_9BDF};
      vecs[7]  = '{"rd_mis",   1, 1, 2'b10, 0, 3'b010, 32'h0000_0002, 32'h0,          32'h9999_9999, 1, 1, 0, 5'h00, 32'h1357_9BDF};
      vecs[8]  = '{"wr_seq",   1, 1, 2'b11, 1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D, 32'h0,          3, 0, 1, 5'h10, 32'h1357_9BDF};
      vecs[9]  = '{"busy_tr",  1, 1, 2'b01, 0, 3'b010, 32'h0000_0014, 32'h0,          32'h0,          0, 0, 0, 5'h00, 32'h1357_9BDF};
      vecs[10] = '{"rd_byte",  1, 1, 2'b10, 0, 3'b000, 32'h0000_0000, 32'h0,          32'h4444_4444, 1, 1, 0, 5'h00, 32'h1357_9BDF};

      // Reset values
      drive_idle();
      #22;
      check("rst psel",    32'(psel),      32'd0);
      check("rst penable", 32'(penable),   32'd0);
      check("rst pwrite",  32'(pwrite),    32'd0);
      check("rst paddr",   32'(paddr),     32'd0);
      check("rst pwdata",  pwdata,         32'd0);
      check("rst hrdata",  hrdata,         32'd0);
      check("rst hready",  32'(hreadyout), 32'd1);
      check("rst hresp",   32'(hresp),     32'd0);
      @(posedge pclk); #1;
      n_preset = 1'b1;
      step();

      for (int i = 0; i < 11; i++) run_txn(vecs[i]);
      check("nop keeps paddr",  32'(paddr), 32'h10);
      check("nop keeps pwdata", pwdata,     32'h0BAD_F00D);

      // Back-to-back: read, write in its completion cycle, read in the write's completion cycle
      drive_addr(1'b0, 32'h0000_0008); prdata = 32'h1111_2222;
      step(); drive_idle();                                            // T1
      check("b2b rd setup psel", 32'(psel), 32'd1);
      check("b2b rd setup pen",  32'(penable), 32'd0);
      step();                                                          // T2
      check("b2b rd enable",     32'({psel, penable}), 32'b11);
      check("b2b rd paddr",      32'(paddr), 32'h08);
      step();                                                          // T3
      check("b2b rd done hready", 32'(hreadyout), 32'd1);
      check("b2b rd hrdata",      hrdata, 32'h1111_2222);
      drive_addr(1'b1, 32'h0000_000C);
      step(); drive_idle(); hwdata = 32'h3333_4444;                    // T4 WDATA
      check("b2b wr wdata psel", 32'(psel), 32'd0);
      check("b2b wr wdata hrdy", 32'(hreadyout), 32'd0);
      step();                                                          // T5 SETUP
      check("b2b wr setup", 32'({psel, penable, pwrite}), 32'b101);
      check("b2b wr paddr", 32'(paddr), 32'h0C);
      check("b2b wr pwdata", pwdata, 32'h3333_4444);
      step();                                                          // T6 ENABLE
      check("b2b wr enable", 32'({psel, penable}), 32'b11);
      step();                                                          // T7
      check("b2b wr done hready", 32'(hreadyout), 32'd1);
      check("b2b wr keeps hrdata", hrdata, 32'h1111_2222);
      drive_addr(1'b0, 32'h0000_0014); prdata = 32'h5555_6666;
      step(); drive_idle();                                            // T8
      check("b2b rd2 setup", 32'({psel, penable, pwrite}), 32'b100);
      check("b2b rd2 paddr", 32'(paddr), 32'h14);
      step();                                                          // T9
      check("b2b rd2 enable", 32'({psel, penable}), 32'b11);
      step();                                                          // T10
      check("b2b rd2 hrdata", hrdata, 32'h5555_6666);
      check("b2b rd2 hready", 32'(hreadyout), 32'd1);
      step();

      // Asynchronous reset during the ENABLE cycle of a write
      drive_addr(1'b1, 32'h0000_0018);
      step(); drive_idle(); hwdata = 32'hCAFE_F00D;
      step(); step();
      check("rst_mid enable", 32'({psel, penable}), 32'b11);
      check("rst_mid pwdata before", pwdata, 32'hCAFE_F00D);
      #3 n_preset = 1'b0;
      #1;
      check("rst_mid psel",    32'(psel),      32'd0);
      check("rst_mid penable", 32'(penable),   32'd0);
      check("rst_mid pwdata",  pwdata,         32'd0);
      check("rst_mid paddr",   32'(paddr),     32'd0);
      check("rst_mid pwrite",  32'(pwrite),    32'd0);
      check("rst_mid hrdata",  hrdata,         32'd0);
      check("rst_mid hready",  32'(hreadyout), 32'd1);
      check("rst_mid hresp",   32'(hresp),     32'd0);
      step();
      n_preset = 1'b1;
      step();
      run_txn('{"rd_after_rst", 1, 1, 2'b10, 0, 3'b010, 32'h0000_0000, 32'h0, 32'h0F0F_0F0F,
                2, 0, 1, 5'h00, 32'h0F0F_0F0F});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
